// File: rtl/dmem_responder.sv
// Word-organised data memory with programmable wait states behind a valid/ready request port.
// Byte-lane store enables are compiled in with DMEM_WSTRB_EN.
module dmem_responder #(
    parameter int DEPTH = 1024,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef DMEM_WSTRB_EN
    input  logic [3:0]  req_wstrb,
`endif
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic [3:0]    cnt;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
`ifdef DMEM_WSTRB_EN
    logic [3:0]    wstrb_q;
`endif
    logic          accept;
    logic          err;
    logic [AW-1:0] idx;

    // Contents survive reset; only the power-on value is zero.
    logic [31:0] mem [DEPTH] = '{default: '0};

    assign accept    = req_valid && (state == S_IDLE);
    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);

    assign idx = addr_q[AW+1:2];
    assign err = (addr_q[1:0] != 2'b00) ||
                 ({2'b00, addr_q[31:2]} >= 32'(DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (accept) state_nxt = (WAIT > 0) ? S_WAIT : S_ACCESS;
            end
            S_WAIT: begin
                if (cnt == 4'd0) state_nxt = S_ACCESS;
            end
            S_ACCESS: state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef DMEM_WSTRB_EN
            wstrb_q <= '0;
`endif
        end else if (accept) begin
            cnt     <= CNT_INIT;
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
`ifdef DMEM_WSTRB_EN
            wstrb_q <= req_wstrb;
`endif
        end else if (state == S_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Response registers hold until the next access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (state == S_ACCESS) begin
            rsp_err   <= err;
            rsp_rdata <= (!we_q && !err) ? mem[idx] : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_ACCESS && we_q && !err) begin
`ifdef DMEM_WSTRB_EN
            for (int k = 0; k < 4; k++) begin
                if (wstrb_q[k]) mem[idx][8*k +: 8] <= wdata_q[8*k +: 8];
            end
`else
            mem[idx] <= wdata_q;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with WAIT=2, one with WAIT=0.
// Byte-lane checks are built only when DMEM_WSTRB_EN is defined.
module tb_dmem_responder;

    logic clk;
    logic reset;

    logic        rv  [2];
    logic        rwe [2];
    logic [31:0] ra  [2];
    logic [31:0] rwd [2];
    logic [3:0]  rws [2];
    logic        rdy [2];
    logic        vld [2];
    logic [31:0] rd  [2];
    logic        er  [2];

    int checks;
    int failures;

    dmem_responder #(.DEPTH(1024), .WAIT(2)) u_w2 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (rv[0]),
        .req_ready (rdy[0]),
        .req_we    (rwe[0]),
        .req_addr  (ra[0]),
        .req_wdata (rwd[0]),
`ifdef DMEM_WSTRB_EN
        .req_wstrb (rws[0]),
`endif
        .rsp_valid (vld[0]),
        .rsp_rdata (rd[0]),
        .rsp_err   (er[0])
    );

    dmem_responder #(.DEPTH(16), .WAIT(0)) u_w0 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (rv[1]),
        .req_ready (rdy[1]),
        .req_we    (rwe[1]),
        .req_addr  (ra[1]),
        .req_wdata (rwd[1]),
`ifdef DMEM_WSTRB_EN
        .req_wstrb (rws[1]),
`endif
        .rsp_valid (vld[1]),
        .rsp_rdata (rd[1]),
        .rsp_err   (er[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE and wait (bounded) for its response pulse.
    task automatic req(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       output logic [31:0] rdata, output logic e,
                       output int lat, output int low);
        bit found;
        @(negedge clk);
        chk("ready_before_req", 32'(rdy[d]), 32'd1);
        rv[d]  = 1'b1;
        rwe[d] = we;
        ra[d]  = addr;
        rwd[d] = wdata;
        rws[d] = strb;
        @(posedge clk);
        #1 rv[d] = 1'b0;
        lat = 0;
        low = 0;
        found = 0;
        rdata = '0;
        e = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!rdy[d]) low++;
            if (vld[d]) begin
                found = 1;
                rdata = rd[d];
                e = er[d];
                break;
            end
            @(posedge clk);
            lat++;
        end
        chk("rsp_seen", 32'(found), 32'd1);
        @(negedge clk);
        chk("rsp_one_cycle", 32'(vld[d]), 32'd0);
        chk("ready_after_rsp", 32'(rdy[d]), 32'd1);
    endtask

    logic [31:0] rdata;
    logic        e;
    int          lat;
    int          low;
    int          nv;
    int          n;
    int          acc [3];
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_val  [3];

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rv[d]  = 1'b0;
            rwe[d] = 1'b0;
            ra[d]  = '0;
            rwd[d] = '0;
            rws[d] = 4'hF;
        end
        b2b_addr[0] = 32'h0; b2b_val[0] = 32'hA0A0_0001;
        b2b_addr[1] = 32'h4; b2b_val[1] = 32'hB1B1_0002;
        b2b_addr[2] = 32'h8; b2b_val[2] = 32'hC2C2_0003;

        // Asynchronous reset between clock edges
        #2 reset = 1'b1;
        #1;
        chk("rst_ready", 32'(rdy[0]), 32'd1);
        chk("rst_valid", 32'(vld[0]), 32'd0);
        chk("rst_rdata", rd[0], 32'd0);
        chk("rst_err", 32'(er[0]), 32'd0);
        chk("rst_ready_w0", 32'(rdy[1]), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Store then load, WAIT=2
        req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rdata, e, lat, low);
        chk("st_latency", 32'(lat), 32'd3);
        chk("st_ready_low", 32'(low), 32'd4);
        chk("st_err", 32'(e), 32'd0);
        chk("st_rdata_zero", rdata, 32'd0);

        req(0, 1'b0, 32'h10, 32'h0, 4'hF, rdata, e, lat, low);
        chk("ld_latency", 32'(lat), 32'd3);
        chk("ld_ready_low", 32'(low), 32'd4);
        chk("ld_rdata", rdata, 32'hDEADBEEF);
        chk("ld_err", 32'(e), 32'd0);
        repeat (3) @(negedge clk);
        chk("rdata_hold", rd[0], 32'hDEADBEEF);

        // Misaligned load
        req(0, 1'b0, 32'h13, 32'h0, 4'hF, rdata, e, lat, low);
        chk("mis_err", 32'(e), 32'd1);
        chk("mis_rdata", rdata, 32'd0);

        // Out-of-range store must not alias onto word 0
        req(0, 1'b1, 32'h1000, 32'h11111111, 4'hF, rdata, e, lat, low);
        chk("oor_err", 32'(e), 32'd1);
        req(0, 1'b0, 32'h0, 32'h0, 4'hF, rdata, e, lat, low);
        chk("word0_unchanged", rdata, 32'd0);
        chk("word0_err", 32'(e), 32'd0);

        // Reset while the store sits in WAIT
        @(negedge clk);
        rv[0] = 1'b1; rwe[0] = 1'b1; ra[0] = 32'h20; rwd[0] = 32'h12345678;
        @(posedge clk);
        #1 rv[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_ready", 32'(rdy[0]), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (vld[0]) nv++;
        end
        chk("midrst_no_rsp", 32'(nv), 32'd0);
        req(0, 1'b0, 32'h20, 32'h0, 4'hF, rdata, e, lat, low);
        chk("midrst_discarded", rdata, 32'd0);

        // WAIT=0 with req_valid held high
        n = 0;
        for (int c = 0; c < 30 && n < 3; c++) begin
            @(negedge clk);
            rv[1]  = 1'b1;
            rwe[1] = 1'b1;
            ra[1]  = b2b_addr[n];
            rwd[1] = b2b_val[n];
            if (rdy[1]) begin
                acc[n] = c;
                n++;
            end
        end
        @(negedge clk);
        rv[1] = 1'b0;
        chk("b2b_accepts", 32'(n), 32'd3);
        if (n == 3) begin
            chk("b2b_gap01", 32'(acc[1] - acc[0]), 32'd3);
            chk("b2b_gap12", 32'(acc[2] - acc[1]), 32'd3);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            req(1, 1'b0, b2b_addr[i], 32'h0, 4'hF, rdata, e, lat, low);
            chk("b2b_readback", rdata, b2b_val[i]);
            if (i == 0) chk("w0_latency", 32'(lat), 32'd1);
        end

        // Store immediately followed by a load of the same word
        req(1, 1'b1, 32'h3C, 32'h5A5A_A5A5, 4'hF, rdata, e, lat, low);
        req(1, 1'b0, 32'h3C, 32'h0, 4'hF, rdata, e, lat, low);
        chk("raw_same_word", rdata, 32'h5A5A_A5A5);

`ifdef DMEM_WSTRB_EN
        req(0, 1'b1, 32'h40, 32'hAABBCCDD, 4'hF, rdata, e, lat, low);
        req(0, 1'b1, 32'h40, 32'h11223344, 4'b0101, rdata, e, lat, low);
        chk("strb_err", 32'(e), 32'd0);
        req(0, 1'b0, 32'h40, 32'h0, 4'hF, rdata, e, lat, low);
        chk("strb_merge", rdata, 32'hAA22CC44);
        req(0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000, rdata, e, lat, low);
        chk("strb_zero_err", 32'(e), 32'd0);
        req(0, 1'b0, 32'h40, 32'h0, 4'hF, rdata, e, lat, low);
        chk("strb_zero_nowrite", rdata, 32'hAA22CC44);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder servicing the MEM stage's load/store requests over a valid/ready request channel and a one-cycle response pulse. It replaces direct hierarchical access to the CPU data array with a word-organised memory that has a configurable number of wait states. It sits between the MEM stage and the data array. The pipeline stalls on `req_ready` / `rsp_valid`.

## Interface
- `DEPTH`, 1024: number of 32-bit words stored.
- `WAIT`, 2: extra wait-state cycles inserted before each access (0..15).
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address (EXMEM ALU result).
- `req_wdata` in 32: store data (EXMEM B).
- `req_wstrb` in 4: byte-lane write enables. Present only with `DMEM_WSTRB_EN`.
- `rsp_valid` out 1: one-cycle pulse marking load data or store completion.
- `rsp_rdata` out 32: load data. Zero for stores and errors.
- `rsp_err` out 1: misaligned or out-of-range access, qualified by `rsp_valid`.

## Operation
- Word index = `req_addr[31:2]`.
- Error conditions:
  - `req_addr[1:0] != 0` → misaligned.
  - index ≥ `DEPTH` → out of range.
  - On either error: no write, `rsp_rdata` = 0, `rsp_err` = 1.
- FSM states: IDLE, WAIT, ACCESS, RESP.
  - IDLE: `req_ready` = 1. On `req_valid && req_ready`, latch `we`, `addr`, `wdata` (and `wstrb`).
    - Go to WAIT with counter = `WAIT`-1 if `WAIT` > 0.
    - Otherwise go directly to ACCESS.
  - WAIT: `req_ready` = 0. Counter decrements each cycle. Go to ACCESS when counter == 0.
  - ACCESS: `req_ready` = 0.
    - Load: register the array word into `rsp_rdata`.
    - Store: write the array.
    - Register `rsp_err`, then go to RESP.
  - RESP: `rsp_valid` = 1 for exactly this cycle. `req_ready` = 0. Go to IDLE.
- Inputs are ignored outside IDLE. Request fields are sampled only on the accept edge.
- The response channel has no backpressure. The consumer must take the response in the RESP cycle.
- Array contents are initialised to 0 at time zero and are **not** cleared by `reset`.
- `reset` asserted (any state) → IDLE immediately.
  - A latched store that has not reached ACCESS is discarded. The array is unchanged.
  - A store already written in ACCESS persists.
- Reset values: `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0. Wait counter = 0.
- `rsp_rdata` and `rsp_err` hold their values after RESP until the next ACCESS.

## Timing
- Accept at edge N.
- Access at edge N+1+`WAIT`.
- `rsp_valid` high during the cycle following edge N+1+`WAIT`.
- Back in IDLE (`req_ready` = 1) after edge N+2+`WAIT`.
- Minimum request spacing: `WAIT`+3 cycles. With `WAIT` = 0: accept, ACCESS, RESP, IDLE.
- Read-after-write to the same word in consecutive requests returns the new data.
- `req_ready` depends only on state, never combinationally on `req_valid`.

## Configuration
- `DMEM_WSTRB_EN` defined:
  - Port `req_wstrb` exists.
  - Store writes byte lane k only where `wstrb[k]` = 1. Lane 0 = bits 7:0.
  - `wstrb` = 0 completes normally with no write and no error.
- `DMEM_WSTRB_EN` undefined:
  - No `req_wstrb` port.
  - Every non-error store writes all 32 bits.

## Test plan
- **Reset state.** Assert `reset` mid-cycle with no clock edge → `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0 immediately.
- **Store/load, `WAIT` = 2.**
  - Store 0xDEADBEEF to addr 0x10 → `rsp_valid` pulse 3 cycles after accept, `rsp_err` = 0.
  - Load addr 0x10 → `rsp_rdata` = 0xDEADBEEF.
  - `req_ready` low for 4 cycles after each accept.
- **Errors.**
  - Load addr 0x13 → `rsp_err` = 1, `rsp_rdata` = 0.
  - Store 0x11111111 to addr 4*`DEPTH` → `rsp_err` = 1. Word 0 is unchanged on readback.
- **Reset mid-operation.** Store 0x12345678 to addr 0x20. Assert `reset` one cycle after accept (in WAIT) → no `rsp_valid`. Load addr 0x20 → 0.
- **`WAIT` = 0 back-to-back.** Hold `req_valid` high with stores to 0x0, 0x4, 0x8 → one accept every 3 cycles. Reads return each value in order.
- **`DMEM_WSTRB_EN`.** Word 0x40 = 0xAABBCCDD. Store 0x11223344 with `wstrb` = 4'b0101 → readback 0xAA22CC44.
